elm_output_layer_ctrl: RTL
==========================

Name: elm_output_layer_ctrl

Overview:
Sequencer for the ELM output layer. On a start pulse it computes each output neuron's dot product of the hidden-layer activation vector with that neuron's weight row, using one shared multiply-accumulate unit and time multiplexing across the neurons. It streams each score out with a 1-based neuron index, tracks the running argmax and reports the classified digit. It sits between the hidden-activation buffer and weight ROM on one side and the digit display/readout on the other.

Parameters:
N_HIDDEN, 64, number of hidden neurons (dot-product length), >=2
N_OUT, 10, number of output neurons/classes, <=15
DW, 16, signed data width of activations, weights and scores
FRAC, 8, fractional bits of the fixed-point format (Q(DW-FRAC).FRAC)
AW, 10, weight address width, >= clog2(N_OUT*N_HIDDEN)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle request to classify; ignored unless IDLE
h_addr  out  clog2(N_HIDDEN)  hidden-activation buffer read address
w_addr  out  AW  weight ROM read address = j*N_HIDDEN + k
h_data  in  DW signed  activation, valid 1 cycle after h_addr
w_data  in  DW signed  weight, valid 1 cycle after w_addr
score  out  DW signed  saturated score of current neuron
score_valid  out  1  one-cycle strobe, score/score_idx valid
score_idx  out  4  1-based neuron index (1..N_OUT) of score
digit  out  4  argmax class, 0-based, held until next completion
digit_valid  out  1  one-cycle strobe when digit updates
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle strobe, coincident with digit_valid

Behaviour:
- States: IDLE, MAC, DRAIN, EMIT, FINAL. All outputs registered.
- Reset (any state, including mid-run): state=IDLE; accumulator, j, k, score, score_idx, digit, h_addr, w_addr = 0; all strobes and busy = 0. Memory data in flight is discarded.
- IDLE: if start, clear acc, set j=0, k=0 and go to MAC. start in any other state is ignored.
- MAC: lasts N_HIDDEN cycles. Presents h_addr=k and w_addr=j*N_HIDDEN+k, with k running 0..N_HIDDEN-1, then goes to DRAIN.
- Data valid flag: a 1-cycle-delayed copy of the MAC flag. On each cycle where it is set, acc += h_data*w_data.
- Product width: 2*DW. Accumulator width: 2*DW+clog2(N_HIDDEN), signed; it never overflows.
- DRAIN: 1 cycle. Absorbs the last product. At the end of DRAIN, score is loaded with sat(acc_final >>> FRAC), where acc_final includes the last product. The shift is arithmetic.
- Saturation: results >2^(DW-1)-1 clamp to 2^(DW-1)-1; results <-2^(DW-1) clamp to -2^(DW-1).
- EMIT: 1 cycle. score_valid=1 and score_idx=j+1.
- Argmax update in EMIT: if j==0, max=score and best=0. Otherwise, if score > max (strict, signed), max=score and best=j. Ties keep the lower index. Negative scores take part in the comparison.
- After EMIT: clear acc, j++. If the new j < N_OUT, go to MAC; otherwise go to FINAL.
- FINAL: 1 cycle. digit=best, digit_valid=1, done=1, then go to IDLE.
- Timing: start is sampled at edge 0. Neuron j MAC covers cycles 1+j*(N_HIDDEN+2) .. +N_HIDDEN-1. EMIT for neuron j falls at cycle 1+j*(N_HIDDEN+2)+N_HIDDEN+1. FINAL falls at cycle 1+N_OUT*(N_HIDDEN+2), which is 661 for the defaults.
- Outside the strobe cycles, score, score_idx and digit hold their last values. The addresses hold their last values outside MAC.
- start is accepted in the cycle immediately after FINAL, so back-to-back runs are allowed.

Test Plan:
- All weights 0, any activations -> 10 score strobes with score=0 and score_idx=1..10; digit=0 (tie resolves to lowest index); done at cycle 661.
- All h=0x0100 (1.0); row 7 weights 0x0080 (0.5), other rows 0x0040 -> scores 8192 for idx 8 and 4096 for all others; digit=7.
- h=0x7FFF, w=0x7FFF for every row -> score=0x7FFF; w=0x8000 for every row -> score=0x8000 (saturation both directions).
- All scores negative with row 3 least negative (h=0x0100, row 3 w=0xFFF0, others w=0xFF00) -> digit=3; a zero-initialised max must not mask this.
- Address check: h_addr sequence 0..63 repeats 10 times; w_addr runs 0..639 contiguously with a 2-cycle gap per row. start pulsed at cycles 5 and 300 of a run -> no restart, same results.
- rst asserted at cycle 200 -> next cycle busy=0, outputs cleared and no done. A fresh start then produces correct results with done at cycle 661 relative to the new start.

Source files
------------

// File: rtl/elm_output_layer_ctrl_if.sv
// Port bundle between the ELM output-layer sequencer, its activation/weight
// memories and the score/digit readout. master = sequencer side.
interface elm_output_layer_ctrl_if #(
  parameter int N_HIDDEN = 64,
  parameter int N_OUT    = 10,
  parameter int DW       = 16,
  parameter int AW       = 10
);
  localparam int HW = $clog2(N_HIDDEN);

  logic                 start;
  logic [HW-1:0]        h_addr;
  logic [AW-1:0]        w_addr;
  logic signed [DW-1:0] h_data;
  logic signed [DW-1:0] w_data;
  logic signed [DW-1:0] score;
  logic                 score_valid;
  logic [3:0]           score_idx;
  logic [3:0]           digit;
  logic                 digit_valid;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, h_data, w_data,
    output h_addr, w_addr, score, score_valid, score_idx,
           digit, digit_valid, busy, done
  );

  modport slave (
    output start, h_data, w_data,
    input  h_addr, w_addr, score, score_valid, score_idx,
           digit, digit_valid, busy, done
  );
endinterface

// File: rtl/elm_output_layer_ctrl.sv
// ELM output-layer sequencer: one shared MAC time-multiplexed over N_OUT
// neurons, streams saturated scores and reports the running argmax digit.
module elm_output_layer_ctrl #(
  parameter int N_HIDDEN = 64,
  parameter int N_OUT    = 10,
  parameter int DW       = 16,
  parameter int FRAC     = 8,
  parameter int AW       = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  elm_output_layer_ctrl_if.master bus
);
  localparam int HW    = $clog2(N_HIDDEN);
  localparam int ACC_W = 2*DW + HW;

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, EMIT, FINAL} state_t;

  state_t                  state;
  logic [HW-1:0]           k;
  logic [3:0]              j;
  logic signed [ACC_W-1:0] acc;
  logic                    vld_p1;
  logic signed [DW-1:0]    max_score;
  logic [3:0]              best;

  logic signed [2*DW-1:0]  prod_p1;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_in;
  logic signed [ACC_W-1:0] acc_shr;
  logic                    upd;
  logic [3:0]              new_best;

  function automatic logic signed [DW-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    lo = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    if (v > hi)      return {1'b0, {(DW-1){1'b1}}};
    else if (v < lo) return {1'b1, {(DW-1){1'b0}}};
    else             return v[DW-1:0];
  endfunction

  // Stage p1: memory data arrives one cycle after the address, tagged by vld_p1
  assign prod_p1  = bus.h_data * bus.w_data;
  assign acc_sum  = acc + {{HW{prod_p1[2*DW-1]}}, prod_p1};
  assign acc_in   = vld_p1 ? acc_sum : acc;
  assign acc_shr  = acc_in >>> FRAC;

  // First neuron seeds the max so all-negative score sets are handled
  assign upd      = (j == 4'd0) || (bus.score > max_score);
  assign new_best = upd ? j : best;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      k               <= '0;
      j               <= '0;
      acc             <= '0;
      vld_p1          <= 1'b0;
      max_score       <= '0;
      best            <= '0;
      bus.h_addr      <= '0;
      bus.w_addr      <= '0;
      bus.score       <= '0;
      bus.score_valid <= 1'b0;
      bus.score_idx   <= '0;
      bus.digit       <= '0;
      bus.digit_valid <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      vld_p1          <= (state == MAC);
      bus.score_valid <= 1'b0;
      bus.digit_valid <= 1'b0;
      bus.done        <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc        <= '0;
            j          <= '0;
            k          <= '0;
            bus.h_addr <= '0;
            bus.w_addr <= '0;
            bus.busy   <= 1'b1;
            state      <= MAC;
          end
        end
        MAC: begin
          acc <= acc_in;
          if (k == HW'(N_HIDDEN-1)) begin
            state <= DRAIN;
          end else begin
            k          <= k + 1'b1;
            bus.h_addr <= k + 1'b1;
            bus.w_addr <= bus.w_addr + 1'b1;
          end
        end
        // Stage p2: last product absorbed, score scaled and clamped
        DRAIN: begin
          acc             <= acc_in;
          bus.score       <= sat(acc_shr);
          bus.score_valid <= 1'b1;
          bus.score_idx   <= j + 4'd1;
          state           <= EMIT;
        end
        EMIT: begin
          if (upd) begin
            max_score <= bus.score;
            best      <= j;
          end
          acc <= '0;
          k   <= '0;
          j   <= j + 4'd1;
          if (j == 4'(N_OUT-1)) begin
            bus.digit       <= new_best;
            bus.digit_valid <= 1'b1;
            bus.done        <= 1'b1;
            state           <= FINAL;
          end else begin
            bus.h_addr <= '0;
            bus.w_addr <= bus.w_addr + 1'b1;
            state      <= MAC;
          end
        end
        FINAL: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
